// File: rtl/nmr_bstrm_serializer.sv
// rtl/nmr_bstrm_serializer.sv - one-deep buffered command word to gapless 1-bit stream serializer
//
// Purpose: accepts {pattern, length} command words from the bitstream sequencer
// into a one-deep holding buffer. Each word is streamed as a 1-bit output for
// exactly 'length' clocks. The output is either the rotating pattern (LSB
// first), constant 1, or constant 0. Consecutive words abut with no idle cycle.
//
// Ports:
//   CLK              system clock, rising edge
//   RST              synchronous active-high reset
//   DPATH_START      one-cycle strobe, word inputs valid
//   DATA_IN          {pattern[PAT_WIDTH-1:0], length[LEN_WIDTH-1:0]}
//   SEQ_END_IN       end-of-sequence marker
//   PATTERN_MODE_IN  stream pattern bits
//   ALL_1S_MODE_IN   stream constant 1
//   ALL_0S_MODE_IN   stream constant 0
//   DPATH_BUF_RDY    holding buffer empty
//   BSTRM_OUT        registered serial output
//   BSTRM_ACTIVE     a word is being streamed
//   SEQ_DONE         one-cycle pulse when the end marker is consumed
//   UNDERRUN         sticky, stream ran dry without an end marker
//   OVERRUN          sticky, START arrived while the buffer was full
module nmr_bstrm_serializer #(
   parameter int DATA_WIDTH = 120,
   parameter int LEN_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  DPATH_START,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  SEQ_END_IN,
   input  logic                  PATTERN_MODE_IN,
   input  logic                  ALL_1S_MODE_IN,
   input  logic                  ALL_0S_MODE_IN,
   output logic                  DPATH_BUF_RDY,
   output logic                  BSTRM_OUT,
   output logic                  BSTRM_ACTIVE,
   output logic                  SEQ_DONE,
   output logic                  UNDERRUN,
   output logic                  OVERRUN
);

   localparam int PAT_WIDTH = DATA_WIDTH - LEN_WIDTH;

   typedef enum logic {IDLE, RUN} state_t;

   state_t state_q, state_nxt;

   // holding buffer; mode is decoded at capture time into two bits
   logic                  buf_full_q;
   logic                  buf_end_q;
   logic                  buf_pat_q;
   logic                  buf_one_q;
   logic [PAT_WIDTH-1:0]  buf_pattern_q;
   logic [LEN_WIDTH-1:0]  buf_len_q;

   // active shifter
   logic [PAT_WIDTH-1:0]  pat_q;
   logic [LEN_WIDTH-1:0]  rem_q;
   logic                  cur_pat_q;
   logic                  cur_one_q;

   logic                  underrun_q;
   logic                  overrun_q;
   logic                  out_q;
   logic                  done_q;

   // combinational control
   logic                  load;
   logic                  buf_release;
   logic                  done_set;
   logic                  underrun_set;
   logic                  out_nxt;
   logic                  capture;
   logic                  overrun_set;
   logic [PAT_WIDTH-1:0]  pat_rot;
   logic [LEN_WIDTH-1:0]  in_len;

   assign pat_rot = {pat_q[0], pat_q[PAT_WIDTH-1:1]};
   assign in_len  = DATA_IN[LEN_WIDTH-1:0];

   // A slot is available when the buffer is empty or is being drained on this
   // same edge. Zero-length data words are dropped; end markers always go in.
   assign capture     = DPATH_START && (!buf_full_q || buf_release) &&
                        (SEQ_END_IN || (in_len != '0));
   assign overrun_set = DPATH_START && buf_full_q && !buf_release;

   always_comb begin
      state_nxt    = state_q;
      load         = 1'b0;
      buf_release  = 1'b0;
      done_set     = 1'b0;
      underrun_set = 1'b0;
      out_nxt      = 1'b0;
      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               buf_release = 1'b1;
               if (buf_end_q) begin
                  done_set = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (rem_q > LEN_WIDTH'(1)) begin
               out_nxt = cur_pat_q ? pat_rot[0] : cur_one_q;
            end else if (buf_full_q) begin
               // word finished: chain the buffered word on this same edge
               buf_release = 1'b1;
               if (buf_end_q) begin
                  done_set  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  load = 1'b1;
               end
            end else begin
               underrun_set = 1'b1;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // the first bit of a freshly loaded word appears on its load edge
      if (load) begin
         out_nxt = buf_pat_q ? buf_pattern_q[0] : buf_one_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         out_q      <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         out_q      <= out_nxt;
         done_q     <= done_set;
         underrun_q <= underrun_q | underrun_set;
         overrun_q  <= overrun_q | overrun_set;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         buf_full_q    <= 1'b0;
         buf_end_q     <= 1'b0;
         buf_pat_q     <= 1'b0;
         buf_one_q     <= 1'b0;
         buf_pattern_q <= '0;
         buf_len_q     <= '0;
      end else if (capture) begin
         buf_full_q    <= 1'b1;
         buf_end_q     <= SEQ_END_IN;
         buf_pat_q     <= PATTERN_MODE_IN;
         buf_one_q     <= !PATTERN_MODE_IN && ALL_1S_MODE_IN;
         buf_pattern_q <= DATA_IN[DATA_WIDTH-1:LEN_WIDTH];
         buf_len_q     <= in_len;
      end else if (buf_release) begin
         buf_full_q <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pat_q     <= '0;
         rem_q     <= '0;
         cur_pat_q <= 1'b0;
         cur_one_q <= 1'b0;
      end else if (load) begin
         pat_q     <= buf_pattern_q;
         rem_q     <= buf_len_q;
         cur_pat_q <= buf_pat_q;
         cur_one_q <= buf_one_q;
      end else if (state_q == RUN && rem_q > LEN_WIDTH'(1)) begin
         pat_q <= pat_rot;
         rem_q <= rem_q - LEN_WIDTH'(1);
      end
   end

   assign DPATH_BUF_RDY = !buf_full_q;
   assign BSTRM_OUT     = out_q;
   assign BSTRM_ACTIVE  = (state_q == RUN);
   assign SEQ_DONE      = done_q;
   assign UNDERRUN      = underrun_q;
   assign OVERRUN       = overrun_q;

endmodule
